rf_read: RTL

Register-file storage and operand read side of the AVR core. It holds R0–R31 and accepts the byte and word writes produced by the write-address/data selector. It decodes the current instruction word and cycle count into Rd, Rr and pointer (X/Y/Z) read addresses, and presents registered operands to the ALU, multiplier, pointer and memory units one cycle later.

---
 rtl/rf_read_pkg.sv | 31 +++
 rtl/rf_read_decode.sv | 50 +++++
 rtl/rf_read.sv | 85 ++++++++
 3 files changed

// File: rtl/rf_read_pkg.sv
// rtl/rf_read_pkg.sv - opcode patterns, pointer indices and pointer-select encoding for rf_read
package rf_read_pkg;

    localparam logic [4:0] XL = 5'd26;
    localparam logic [4:0] YL = 5'd28;
    localparam logic [4:0] ZL = 5'd30;

    typedef enum logic [1:0] {
        PTR_X = 2'd0,
        PTR_Y = 2'd1,
        PTR_Z = 2'd2
    } ptr_sel_t;

    localparam logic [15:0] C_MOVW  = 16'b0000_0001_????_????;
    localparam logic [15:0] C_MULS  = 16'b0000_0010_????_????;
    localparam logic [15:0] C_FMUL  = 16'b0000_0011_????_????;
    localparam logic [15:0] C_CPI   = 16'b0011_????_????_????;
    localparam logic [15:0] C_SBCI  = 16'b0100_????_????_????;
    localparam logic [15:0] C_SUBI  = 16'b0101_????_????_????;
    localparam logic [15:0] C_ORI   = 16'b0110_????_????_????;
    localparam logic [15:0] C_ANDI  = 16'b0111_????_????_????;
    localparam logic [15:0] C_LDI   = 16'b1110_????_????_????;
    localparam logic [15:0] C_ADIW  = 16'b1001_011?_????_????;
    localparam logic [15:0] C_LDX   = 16'b1001_00??_????_1100;
    localparam logic [15:0] C_LDXP  = 16'b1001_00??_????_1101;
    localparam logic [15:0] C_LDXM  = 16'b1001_00??_????_1110;
    localparam logic [15:0] C_LDYP  = 16'b1001_00??_????_1001;
    localparam logic [15:0] C_LDYM  = 16'b1001_00??_????_1010;
    localparam logic [15:0] C_LDDY  = 16'b10?0_??0?_????_1???;

endpackage

// File: rtl/rf_read_decode.sv
// rtl/rf_read_decode.sv - combinational Rd/Rr/pointer address decode from the instruction word
import rf_read_pkg::*;

module rf_read_decode (
    input  logic [15:0] ir,
    input  logic [1:0]  cycle,
    output logic [4:0]  raddr_d,
    output logic [4:0]  raddr_r,
    output ptr_sel_t    ptr_sel
);

    // Later cycles of post-inc/pre-dec ops decode identically; cycle is kept for interface symmetry.
    logic cycle_unused;
    assign cycle_unused = ^cycle;

    always_comb begin
        raddr_d = ir[8:4];
        raddr_r = {ir[9], ir[3:0]};
        casez (ir)
            C_MOVW: begin
                raddr_d = {ir[7:4], 1'b0};
                raddr_r = {ir[3:0], 1'b0};
            end
            C_MULS: begin
                raddr_d = {1'b1, ir[7:4]};
                raddr_r = {1'b1, ir[3:0]};
            end
            C_FMUL: begin
                raddr_d = {2'b10, ir[6:4]};
                raddr_r = {2'b10, ir[2:0]};
            end
            C_CPI, C_SBCI, C_SUBI, C_ORI, C_ANDI, C_LDI:
                raddr_d = {1'b1, ir[7:4]};
            C_ADIW:
                raddr_d = {2'b11, ir[5:4], 1'b0};
            default: ;
        endcase
    end

    // Anything not explicitly X or Y reads Z, so the pointer output stays deterministic.
    always_comb begin
        ptr_sel = PTR_Z;
        casez (ir)
            C_LDX, C_LDXP, C_LDXM: ptr_sel = PTR_X;
            C_LDYP, C_LDYM, C_LDDY: ptr_sel = PTR_Y;
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_read.sv
// rtl/rf_read.sv - AVR register file with registered operand reads; RF_FWD_EN enables same-edge write forwarding
import rf_read_pkg::*;

module rf_read #(
    parameter int         NREG    = 32,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] ir,
    input  logic [1:0]  cycle,
    input  logic [4:0]  waddr,
    input  logic [15:0] wdata,
    input  logic        we_byte,
    input  logic        we_word,
    output logic [15:0] rd_data,
    output logic [15:0] rr_data,
    output logic [15:0] ptr_data,
    output logic [4:0]  rd_addr
);

    logic [7:0]  regs [NREG];
    logic [4:0]  raddr_d;
    logic [4:0]  raddr_r;
    ptr_sel_t    ptr_sel;
    logic [4:0]  ptr_base;
    logic [15:0] rd_next;
    logic [15:0] rr_next;
    logic [15:0] ptr_next;

    rf_read_decode u_decode (
        .ir      (ir),
        .cycle   (cycle),
        .raddr_d (raddr_d),
        .raddr_r (raddr_r),
        .ptr_sel (ptr_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
        end else if (we_word) begin
            regs[{waddr[4:1], 1'b0}] <= wdata[7:0];
            regs[{waddr[4:1], 1'b1}] <= wdata[15:8];
        end else if (we_byte) begin
            regs[waddr] <= wdata[7:0];
        end
    end

    function automatic logic [7:0] read_byte(input logic [4:0] a);
`ifdef RF_FWD_EN
        if (we_word && (a[4:1] == waddr[4:1])) return a[0] ? wdata[15:8] : wdata[7:0];
        if (we_byte && (a == waddr)) return wdata[7:0];
`endif
        return regs[a];
    endfunction

    always_comb begin
        case (ptr_sel)
            PTR_X:   ptr_base = XL;
            PTR_Y:   ptr_base = YL;
            default: ptr_base = ZL;
        endcase
        // 5-bit increment wraps R31's partner to R0.
        rd_next  = {read_byte(raddr_d + 5'd1), read_byte(raddr_d)};
        rr_next  = {read_byte(raddr_r + 5'd1), read_byte(raddr_r)};
        ptr_next = {read_byte(ptr_base + 5'd1), read_byte(ptr_base)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= 16'h0000;
            rr_data  <= 16'h0000;
            ptr_data <= 16'h0000;
            rd_addr  <= 5'd0;
        end else if (en) begin
            rd_data  <= rd_next;
            rr_data  <= rr_next;
            ptr_data <= ptr_next;
            rd_addr  <= raddr_d;
        end
    end

endmodule
